// File: rtl/taxi_apb_if.sv
// rtl/taxi_apb_if.sv - APB bus bundle with manager/subordinate modports
interface taxi_apb_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int STRB_W = DATA_W / 8
) ();
    logic [ADDR_W-1:0] paddr;
    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [DATA_W-1:0] pwdata;
    logic [STRB_W-1:0] pstrb;
    logic [DATA_W-1:0] prdata;
    logic              pready;
    logic              pslverr;

    modport master (
        output paddr, psel, penable, pwrite, pwdata, pstrb,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  paddr, psel, penable, pwrite, pwdata, pstrb,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/taxi_apb_mp_ram.sv
// rtl/taxi_apb_mp_ram.sv - multi-port banked APB RAM with per-bank round-robin arbitration
module taxi_apb_mp_ram #(
    parameter int PORTS           = 2,
    parameter int ADDR_W          = 16,
    parameter int BANKS           = 1,
    parameter int PIPELINE_OUTPUT = 0,
    parameter int DATA_W          = 32
) (
    input  logic      clk,
    input  logic      rst,
    taxi_apb_if.slave s_apb [PORTS]
);
    localparam int STRB_W = DATA_W / 8;
    localparam int OFF_W  = $clog2(STRB_W);
    localparam int WORD_W = ADDR_W - OFF_W;
    localparam int LB     = $clog2(BANKS);
    localparam int ROW_W  = WORD_W - LB;
    localparam int ROWS   = 2 ** ROW_W;
    localparam int PW     = (PORTS > 1) ? $clog2(PORTS) : 1;
    localparam int BW     = (BANKS > 1) ? LB : 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    logic [PORTS-1:0]  p_sel;
    logic [PORTS-1:0]  p_enable;
    logic [PORTS-1:0]  p_write;
    logic [ROW_W-1:0]  p_row   [PORTS];
    logic [BW-1:0]     p_bank  [PORTS];
    logic [DATA_W-1:0] p_wdata [PORTS];
    logic [STRB_W-1:0] p_strb  [PORTS];
    logic [PORTS-1:0]  req;
    logic [PORTS-1:0]  granted;
    logic [PORTS-1:0]  pready_out;

    logic [BANKS-1:0]  gnt_valid;
    logic [PW-1:0]     gnt_port   [BANKS];
    logic [DATA_W-1:0] bank_rdata [BANKS];

    for (genvar i = 0; i < PORTS; i++) begin : g_port
        logic [WORD_W-1:0] word;
        logic [1:0]        state;
        logic              pready_s0;
        logic [BW-1:0]     resp_bank;
        logic [DATA_W-1:0] data_s0;

        assign p_sel[i]    = s_apb[i].psel;
        assign p_enable[i] = s_apb[i].penable;
        assign p_write[i]  = s_apb[i].pwrite;
        assign p_wdata[i]  = s_apb[i].pwdata;
        assign p_strb[i]   = s_apb[i].pstrb;

        // Upper address bits are dropped so the memory aliases; low bits pick the bank
        assign word     = s_apb[i].paddr[ADDR_W-1:OFF_W];
        assign p_row[i] = word[WORD_W-1:LB];
        if (BANKS > 1) begin : g_bank_sel
            assign p_bank[i] = word[LB-1:0];
        end else begin : g_one_bank
            assign p_bank[i] = 1'b0;
        end

        // Only an access phase that has not been answered yet competes for its bank
        assign req[i]     = p_sel[i] && p_enable[i] && (state == ST_IDLE || state == ST_WAIT);
        assign granted[i] = gnt_valid[p_bank[i]] && (gnt_port[p_bank[i]] == PW'(i));

        // Per-port transfer tracking: idle, waiting for the bank, responding
        always_ff @(posedge clk) begin
            if (rst) begin
                state <= ST_IDLE;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (granted[i])
                            state <= ST_RESP;
                        else if (p_sel[i] && p_enable[i])
                            state <= ST_WAIT;
                    end
                    ST_WAIT: begin
                        if (granted[i])
                            state <= ST_RESP;
                        else if (!(p_sel[i] && p_enable[i]))
                            state <= ST_IDLE;
                    end
                    ST_RESP: begin
                        if (pready_out[i])
                            state <= ST_IDLE;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end

        // First response stage: remember which bank holds this port's read data
        always_ff @(posedge clk) begin
            if (rst) begin
                pready_s0 <= 1'b0;
                resp_bank <= '0;
            end else begin
                pready_s0 <= granted[i];
                if (granted[i])
                    resp_bank <= p_bank[i];
            end
        end

        assign data_s0 = pready_s0 ? bank_rdata[resp_bank] : '0;

        if (PIPELINE_OUTPUT != 0) begin : g_pipe
            logic              pready_s1;
            logic [DATA_W-1:0] data_s1;

            // Optional output register trading one wait state for timing
            always_ff @(posedge clk) begin
                if (rst) begin
                    pready_s1 <= 1'b0;
                    data_s1   <= '0;
                end else begin
                    pready_s1 <= pready_s0;
                    data_s1   <= data_s0;
                end
            end

            assign pready_out[i]   = pready_s1;
            assign s_apb[i].prdata = data_s1;
        end else begin : g_direct
            assign pready_out[i]   = pready_s0;
            assign s_apb[i].prdata = data_s0;
        end

        assign s_apb[i].pready  = pready_out[i];
        assign s_apb[i].pslverr = 1'b0;
    end

    for (genvar b = 0; b < BANKS; b++) begin : g_bank
        logic [DATA_W-1:0] mem [ROWS];
        logic [PW-1:0]     last_grant;
        logic [PW-1:0]     win;
        logic              found;
        logic [DATA_W-1:0] rd_q;

        // Round-robin: first requester on this bank strictly after last_grant, wrapping
        always_comb begin
            int idx;
            found = 1'b0;
            win   = last_grant;
            idx   = 0;
            for (int k = 1; k <= PORTS; k++) begin
                idx = int'(last_grant) + k;
                if (idx >= PORTS)
                    idx = idx - PORTS;
                if (!found && req[idx] && (p_bank[idx] == BW'(b))) begin
                    found = 1'b1;
                    win   = PW'(idx);
                end
            end
        end

        assign gnt_valid[b]  = found;
        assign gnt_port[b]   = win;
        assign bank_rdata[b] = rd_q;

        // Fairness pointer; PORTS-1 after reset gives port 0 first priority
        always_ff @(posedge clk) begin
            if (rst)
                last_grant <= PW'(PORTS - 1);
            else if (found)
                last_grant <= win;
        end

        // Byte-masked write; a grant coinciding with reset must not disturb contents
        always_ff @(posedge clk) begin
            if (found && p_write[win] && !rst) begin
                for (int j = 0; j < STRB_W; j++) begin
                    if (p_strb[win][j])
                        mem[p_row[win]][j*8 +: 8] <= p_wdata[win][j*8 +: 8];
                end
            end
        end

        // Read capture in the grant cycle; writes return zero data
        always_ff @(posedge clk) begin
            if (rst)
                rd_q <= '0;
            else if (found)
                rd_q <= p_write[win] ? '0 : mem[p_row[win]];
        end
    end
endmodule

// File: tb/tb_taxi_apb_mp_ram.sv
// tb/tb_taxi_apb_mp_ram.sv - directed self-checking bench for taxi_apb_mp_ram
module tb_taxi_apb_mp_ram;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a;
    logic rst_b;
    int   total = 0;
    int   bad   = 0;
    logic slverr_seen = 1'b0;

    logic        psel    [2][4];
    logic        penable [2][4];
    logic        pwrite  [2][4];
    logic [31:0] paddr   [2][4];
    logic [31:0] pwdata  [2][4];
    logic [3:0]  pstrb   [2][4];
    logic [31:0] prdata  [2][4];
    logic        pready  [2][4];
    logic        pslverr [2][4];

    logic [31:0] rd [4];
    int          lt [4];

    taxi_apb_if #(.DATA_W(32), .ADDR_W(32)) apb_a [4] ();
    taxi_apb_if #(.DATA_W(32), .ADDR_W(32)) apb_b [2] ();

    taxi_apb_mp_ram #(
        .PORTS(4), .ADDR_W(16), .BANKS(2), .PIPELINE_OUTPUT(0), .DATA_W(32)
    ) dut_a (
        .clk(clk),
        .rst(rst_a),
        .s_apb(apb_a)
    );

    taxi_apb_mp_ram #(
        .PORTS(2), .ADDR_W(16), .BANKS(1), .PIPELINE_OUTPUT(1), .DATA_W(32)
    ) dut_b (
        .clk(clk),
        .rst(rst_b),
        .s_apb(apb_b)
    );

    for (genvar i = 0; i < 4; i++) begin : g_a
        assign apb_a[i].psel    = psel[0][i];
        assign apb_a[i].penable = penable[0][i];
        assign apb_a[i].pwrite  = pwrite[0][i];
        assign apb_a[i].paddr   = paddr[0][i];
        assign apb_a[i].pwdata  = pwdata[0][i];
        assign apb_a[i].pstrb   = pstrb[0][i];
        assign prdata[0][i]     = apb_a[i].prdata;
        assign pready[0][i]     = apb_a[i].pready;
        assign pslverr[0][i]    = apb_a[i].pslverr;
    end

    for (genvar i = 0; i < 2; i++) begin : g_b
        assign apb_b[i].psel    = psel[1][i];
        assign apb_b[i].penable = penable[1][i];
        assign apb_b[i].pwrite  = pwrite[1][i];
        assign apb_b[i].paddr   = paddr[1][i];
        assign apb_b[i].pwdata  = pwdata[1][i];
        assign apb_b[i].pstrb   = pstrb[1][i];
        assign prdata[1][i]     = apb_b[i].prdata;
        assign pready[1][i]     = apb_b[i].pready;
        assign pslverr[1][i]    = apb_b[i].pslverr;
    end

    for (genvar i = 2; i < 4; i++) begin : g_bz
        assign prdata[1][i]  = '0;
        assign pready[1][i]  = 1'b0;
        assign pslverr[1][i] = 1'b0;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One APB transfer; lat counts cycles from the setup cycle to the PREADY cycle
    task automatic apb_xfer(input int d, input int p, input logic wr, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [3:0] strb,
                            output logic [31:0] rdata, output int lat);
        int n;
        logic done;
        @(posedge clk);
        #1;
        psel[d][p]    = 1'b1;
        penable[d][p] = 1'b0;
        pwrite[d][p]  = wr;
        paddr[d][p]   = addr;
        pwdata[d][p]  = wdata;
        pstrb[d][p]   = strb;
        @(posedge clk);
        #1;
        penable[d][p] = 1'b1;
        n     = 1;
        done  = 1'b0;
        rdata = 32'hBAD0BAD0;
        lat   = 99;
        while (!done && n < 20) begin
            @(negedge clk);
            if (pready[d][p]) begin
                rdata = prdata[d][p];
                lat   = n;
                done  = 1'b1;
                if (pslverr[d][p])
                    slverr_seen = 1'b1;
            end else begin
                n++;
            end
        end
        @(posedge clk);
        #1;
        psel[d][p]    = 1'b0;
        penable[d][p] = 1'b0;
    endtask

    logic [31:0] r;
    int          l;
    int          cnt;

    initial begin
        for (int d = 0; d < 2; d++) begin
            for (int p = 0; p < 4; p++) begin
                psel[d][p] = 1'b0; penable[d][p] = 1'b0; pwrite[d][p] = 1'b0;
                paddr[d][p] = '0; pwdata[d][p] = '0; pstrb[d][p] = '0;
            end
        end
        rst_a = 1'b1;
        rst_b = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst_a = 1'b0;
        rst_b = 1'b0;
        @(negedge clk);
        for (int p = 0; p < 4; p++) begin
            check($sformatf("rst_pready_a%0d", p), {31'd0, pready[0][p]}, 32'd0);
            check($sformatf("rst_prdata_a%0d", p), prdata[0][p], 32'd0);
        end
        check("rst_pready_b0", {31'd0, pready[1][0]}, 32'd0);

        // Port 3 writes the shared word, leaving bank 0 pointer at 3
        apb_xfer(0, 3, 1'b1, 32'h48, 32'hCAFE0001, 4'hF, r, l);
        check("prewrite_lat", l, 2);

        // Four-way contention on one word, three rounds
        for (int rr = 0; rr < 3; rr++) begin
            fork
                apb_xfer(0, 0, 1'b0, 32'h48, 32'h0, 4'h0, rd[0], lt[0]);
                apb_xfer(0, 1, 1'b0, 32'h48, 32'h0, 4'h0, rd[1], lt[1]);
                apb_xfer(0, 2, 1'b0, 32'h48, 32'h0, 4'h0, rd[2], lt[2]);
                apb_xfer(0, 3, 1'b0, 32'h48, 32'h0, 4'h0, rd[3], lt[3]);
            join
            for (int p = 0; p < 4; p++) begin
                check($sformatf("cont_r%0d_p%0d_lat", rr, p), lt[p], 2 + p);
                check($sformatf("cont_r%0d_p%0d_data", rr, p), rd[p], 32'hCAFE0001);
            end
        end

        // Basic write/read
        apb_xfer(0, 0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, r, l);
        check("wr_lat", l, 2);
        check("wr_prdata", r, 32'h0);
        apb_xfer(0, 0, 1'b0, 32'h10, 32'h0, 4'h0, r, l);
        check("rd_lat", l, 2);
        check("rd_data", r, 32'hDEADBEEF);

        // Byte strobes
        apb_xfer(0, 0, 1'b1, 32'h20, 32'hFFFFFFFF, 4'hF, r, l);
        apb_xfer(0, 0, 1'b1, 32'h20, 32'h11223344, 4'b0101, r, l);
        apb_xfer(0, 0, 1'b0, 32'h20, 32'h0, 4'h0, r, l);
        check("strb_data", r, 32'hFF22FF44);

        // Zero strobe completes but writes nothing
        apb_xfer(0, 0, 1'b1, 32'h10, 32'h0, 4'h0, r, l);
        check("strb0_lat", l, 2);
        apb_xfer(0, 0, 1'b0, 32'h10, 32'h0, 4'h0, r, l);
        check("strb0_data", r, 32'hDEADBEEF);

        // Aliasing above ADDR_W
        apb_xfer(0, 2, 1'b1, 32'h0001_0030, 32'hA5A5A5A5, 4'hF, r, l);
        apb_xfer(0, 1, 1'b0, 32'h0000_0030, 32'h0, 4'h0, r, l);
        check("alias_data", r, 32'hA5A5A5A5);

        // Bank parallelism: word 0 on bank 0, word 1 on bank 1
        apb_xfer(0, 0, 1'b1, 32'h0, 32'h01010101, 4'hF, r, l);
        apb_xfer(0, 1, 1'b1, 32'h4, 32'h02020202, 4'hF, r, l);
        fork
            apb_xfer(0, 0, 1'b0, 32'h0, 32'h0, 4'h0, rd[0], lt[0]);
            apb_xfer(0, 1, 1'b0, 32'h4, 32'h0, 4'h0, rd[1], lt[1]);
        join
        check("par_lat0", lt[0], 2);
        check("par_lat1", lt[1], 2);
        check("par_data0", rd[0], 32'h01010101);
        check("par_data1", rd[1], 32'h02020202);

        // Bank 0 pointer is now 0, so port 2 beats port 3; port 3 sees the new data
        fork
            apb_xfer(0, 2, 1'b1, 32'h0, 32'h33333333, 4'hF, rd[2], lt[2]);
            apb_xfer(0, 3, 1'b0, 32'h0, 32'h0, 4'h0, rd[3], lt[3]);
        join
        check("rr_lat2", lt[2], 2);
        check("rr_lat3", lt[3], 3);
        check("rr_data3", rd[3], 32'h33333333);

        // Pipelined instance
        apb_xfer(1, 1, 1'b1, 32'h80, 32'h12345678, 4'hF, r, l);
        check("pipe_wr_lat", l, 3);
        apb_xfer(1, 0, 1'b0, 32'h80, 32'h0, 4'h0, r, l);
        check("pipe_rd_lat", l, 3);
        check("pipe_rd_data", r, 32'h12345678);

        // Reset asserted in the grant cycle of a write
        @(posedge clk);
        #1;
        psel[1][0] = 1'b1; penable[1][0] = 1'b0; pwrite[1][0] = 1'b1;
        paddr[1][0] = 32'h80; pwdata[1][0] = 32'h87654321; pstrb[1][0] = 4'hF;
        @(posedge clk);
        #1;
        penable[1][0] = 1'b1;
        rst_b = 1'b1;
        @(posedge clk);
        #1;
        rst_b = 1'b0;
        psel[1][0] = 1'b0;
        penable[1][0] = 1'b0;
        cnt = 0;
        repeat (6) begin
            @(negedge clk);
            if (pready[1][0])
                cnt++;
        end
        check("rst_no_pready", cnt, 0);
        apb_xfer(1, 1, 1'b0, 32'h80, 32'h0, 4'h0, r, l);
        check("post_rst_lat", l, 3);
        check("post_rst_data", r, 32'h12345678);

        check("pslverr", {31'd0, slverr_seen}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end
endmodule

// File: doc/taxi_apb_mp_ram.md
Name: taxi_apb_mp_ram

Overview:
- Multi-port, banked APB RAM on a single clock; successor to the two-clock dual-port APB RAM.
- PORTS independent APB subordinate ports share one storage array of 2**ADDR_W bytes.
- Storage is split into BANKS word-interleaved banks, each with its own round-robin arbiter.
  - Accesses to different banks proceed in parallel.
  - Accesses to the same bank are serialised fairly.
- Used as shared scratch/mailbox memory between several APB managers in one clock domain.

Parameters:
- PORTS, 2: number of APB subordinate ports, 1..16.
- ADDR_W, 16: byte address width of the storage. Size is 2**ADDR_W bytes.
- BANKS, 1: number of word-interleaved banks. Power of two, 1..PORTS*2.
- PIPELINE_OUTPUT, 0: adds one register stage on read data/PREADY, giving 1 extra wait state.
- DATA_W and STRB_W come from the s_apb interface, with STRB_W = DATA_W/8. DATA_W is 8, 16, 32 or 64.

Ports:
- clk, input, 1: clock for all ports and storage.
- rst, input, 1: synchronous, active-high reset.
- s_apb, taxi_apb_if slave modport array, [PORTS]: APB subordinate ports.
  - Uses PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, PRDATA, PREADY, PSLVERR.
  - PADDR width may exceed ADDR_W.

Behaviour:
- Addressing:
  - Word address = PADDR[ADDR_W-1:log2(STRB_W)]. Higher PADDR bits are ignored, so the memory aliases. Low byte-offset bits are ignored.
  - Bank = word_addr[log2(BANKS)-1:0]. Row within bank = the remaining word address bits.
- Request: a port requests in every cycle where PSEL=1, PENABLE=1 and PREADY has not yet been returned for that transfer. The setup phase (PENABLE=0) is never a request.
- Arbitration:
  - Each bank grants at most one requesting port per cycle.
  - Round-robin: winner is the lowest port index strictly above last_grant, wrapping around.
  - last_grant resets to PORTS-1, so port 0 has first priority after reset.
  - A port with no competitor on its bank is granted in its first access-phase cycle.
- Grant cycle G:
  - Write: bytes with PSTRB[i]=1 are written at the end of G. PSTRB=0 writes nothing but still completes.
  - Read: array is read in G.
- Completion:
  - PREADY=1 for exactly one cycle, at G+1 (PIPELINE_OUTPUT=0) or G+2 (PIPELINE_OUTPUT=1).
  - PRDATA is valid only while PREADY=1 and is 0 otherwise. On write completion PRDATA=0.
  - PSLVERR is always 0.
- Latency: an uncontended transfer has 1 wait state, or 2 with PIPELINE_OUTPUT. Each contending port adds 1 cycle per earlier winner.
- Ordering and coherence:
  - A read granted after a write to the same word returns the written data.
  - A read and a write to the same word cannot be granted in the same cycle, because the word maps to one bank.
- Back-to-back: a port may issue a new setup phase in the cycle after PREADY. Throughput per port is one transfer per 3 cycles uncontended.
- Per-port state machine:
  - IDLE -> WAIT when an access phase starts.
  - WAIT -> RESP on grant.
  - RESP -> IDLE after PREADY (RESP spans 1 or 2 cycles per PIPELINE_OUTPUT).
- Protocol violations:
  - If PSEL drops in WAIT before grant, the request is withdrawn with no write and no PREADY. State returns to IDLE.
  - If PSEL drops after grant, the access still takes effect.
  - PADDR/PWDATA changes during WAIT are undefined (not checked).
- Reset:
  - All ports go to IDLE, PREADY=0, PRDATA=0, PSLVERR=0, last_grant=PORTS-1, pipeline registers cleared.
  - In-flight transfers are dropped without PREADY. A write granted in the same cycle as rst=1 is suppressed.
  - RAM contents are NOT cleared and hold across reset.
  - The first request is accepted from the first access phase after rst deasserts.

Test Plan:
- Single port, PIPELINE_OUTPUT=0: write 0xDEADBEEF at 0x0010, then read 0x0010 -> PREADY 2 cycles after setup, PRDATA=0xDEADBEEF, PSLVERR=0.
- Byte strobes: write 0xFFFFFFFF, then write 0x11223344 with PSTRB=0b0101 -> read returns 0xFF22FF44.
- Aliasing: write 0xA5A5A5A5 to 0x0001_0020 (ADDR_W=16), read 0x0000_0020 -> 0xA5A5A5A5.
- Contention, PORTS=4, BANKS=1: all ports read simultaneously, repeated 3 times.
  - First round: grants in order 0,1,2,3, with PREADY at relative cycles +1,+2,+3,+4.
  - Later rounds continue round-robin from last_grant.
  - No port waits more than PORTS-1 extra cycles.
- Bank parallelism, BANKS=2: port 0 targets word 0 (bank 0), port 1 targets word 1 (bank 1) in the same cycle -> both get PREADY in the same cycle.
- PIPELINE_OUTPUT=1 plus reset: start a write and assert rst in its grant cycle -> no PREADY and memory unchanged.
  - After reset, an uncontended read completes with 2 wait states.
  - Data written before reset is still readable.
